// File: rtl/gain_ramp_pkg.sv
// Shared types and constants for the gain slew ramp.
package gain_ramp_pkg;

  // Default widths for the gain datapath (matches the scaler's gain input).
  localparam int GAIN_DATA_WIDTH_DEFAULT = 32;
  localparam int GAIN_DATA_Q_DEFAULT     = 16;

  // Unity gain in Q16.
  localparam logic [31:0] GAIN_UNITY_Q16 = 32'h0001_0000;

  // Ramp direction state.
  typedef enum logic [1:0] {
    HOLD = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } ramp_state_t;

  // Direction a ramp should take given the sign of (target - current).
  function automatic ramp_state_t dir_to_state(input logic diff_pos, input logic diff_neg);
    ramp_state_t s;
    s = HOLD;
    if (diff_pos) begin
      s = UP;
    end else if (diff_neg) begin
      s = DOWN;
    end
    return s;
  endfunction

endpackage

// File: rtl/ramp_tick_gen.sv
// Update-interval counter: fires a one-cycle tick every prescale+1 run cycles.
module ramp_tick_gen #(
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      a_clk,
  input  logic                      a_resetn,
  input  logic                      clear,
  input  logic                      run,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      tick
);

  logic [PRESCALE_WIDTH-1:0] count;

  assign tick = run && (count == prescale);

  // Count while running, wrap to zero on each tick; clear forces zero.
  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run) begin
      if (tick) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gain_slew_ramp.sv
// Slews the scaler gain linearly toward a programmed (or muted) target,
// stepping by a programmable amount at a programmable update rate.
module gain_slew_ramp
  import gain_ramp_pkg::*;
#(
  parameter int GAIN_DATA_WIDTH = GAIN_DATA_WIDTH_DEFAULT,
  parameter int GAIN_DATA_Q     = GAIN_DATA_Q_DEFAULT,
  parameter int STEP_WIDTH      = 32,
  parameter int PRESCALE_WIDTH  = 16
) (
  input  logic                       a_clk,
  input  logic                       a_resetn,
  input  logic [GAIN_DATA_WIDTH-1:0] target_gain,
  input  logic [STEP_WIDTH-1:0]      step,
  input  logic [PRESCALE_WIDTH-1:0]  prescale,
  input  logic                       enable,
  input  logic                       mute,
  output logic [GAIN_DATA_WIDTH-1:0] gain_out,
  output logic                       ramping,
  output logic                       at_target
);

  localparam int GW    = GAIN_DATA_WIDTH;
  localparam int CMP_W = (STEP_WIDTH > GW + 1) ? STEP_WIDTH : GW + 1;

  // The fractional position only matters to the scaler; it must fit the word.
  if (GAIN_DATA_Q >= GAIN_DATA_WIDTH) begin : g_bad_q
    $error("GAIN_DATA_Q must be smaller than GAIN_DATA_WIDTH");
  end

  ramp_state_t      state;
  ramp_state_t      next_state;
  logic [GW-1:0]    eff;
  logic [GW:0]      diff;
  logic [GW:0]      diff_mag;
  logic             diff_pos;
  logic             diff_neg;
  logic [CMP_W-1:0] mag_ext;
  logic [CMP_W-1:0] step_ext;
  logic [GW-1:0]    gain_step;
  logic [GW-1:0]    gain_next;
  logic             ramping_next;
  logic             at_target_next;
  logic             step_zero;
  logic             clamp;
  logic             tick;
  logic             tick_clear;
  logic             tick_run;

  // Effective target and the one-bit-wider signed distance to it, so the
  // extremes (0x7FFF_FFFF -> 0x8000_0000) cannot overflow.
  assign eff       = mute ? '0 : target_gain;
  assign diff      = {eff[GW-1], eff} - {gain_out[GW-1], gain_out};
  assign diff_neg  = diff[GW];
  assign diff_pos  = !diff[GW] && (diff != '0);
  assign diff_mag  = diff_neg ? (~diff + 1'b1) : diff;
  assign mag_ext   = CMP_W'(diff_mag);
  assign step_ext  = CMP_W'(step);
  assign clamp     = (mag_ext <= step_ext);
  assign step_zero = (step == '0);

  // Only reached when |diff| > step, so the result lies strictly between
  // gain_out and eff and the truncated arithmetic cannot wrap.
  assign gain_step = diff_neg ? (gain_out - step_ext[GW-1:0])
                              : (gain_out + step_ext[GW-1:0]);

  assign tick_clear = enable && (state == HOLD);
  assign tick_run   = enable && (state != HOLD);

  ramp_tick_gen #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_tick_gen (
    .a_clk    (a_clk),
    .a_resetn (a_resetn),
    .clear    (tick_clear),
    .run      (tick_run),
    .prescale (prescale),
    .tick     (tick)
  );

  // State register; frozen while disabled.
  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      state <= HOLD;
    end else if (enable) begin
      state <= next_state;
    end
  end

  // Next state: follow the sign of diff, drop to HOLD on a clamping tick or a jump.
  always_comb begin
    next_state = state;
    if (enable) begin
      if (step_zero) begin
        next_state = HOLD;
      end else begin
        case (state)
          HOLD:    next_state = dir_to_state(diff_pos, diff_neg);
          UP,
          DOWN:    next_state = (tick && clamp) ? HOLD : dir_to_state(diff_pos, diff_neg);
          default: next_state = HOLD;
        endcase
      end
    end
  end

  // Next output values: jump, clamp onto eff, or take one step toward it.
  always_comb begin
    gain_next = gain_out;
    if (enable) begin
      if (step_zero) begin
        gain_next = eff;
      end else if ((state != HOLD) && tick) begin
        gain_next = clamp ? eff : gain_step;
      end
    end
    ramping_next   = (next_state != HOLD);
    at_target_next = (gain_next == eff);
  end

  // Output registers, updated alongside the state.
  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      gain_out  <= '0;
      ramping   <= 1'b0;
      at_target <= 1'b0;
    end else if (enable) begin
      gain_out  <= gain_next;
      ramping   <= ramping_next;
      at_target <= at_target_next;
    end
  end

endmodule

// File: tb/tb_gain_slew_ramp.sv
// Directed scoreboard bench for gain_slew_ramp.
module tb_gain_slew_ramp;
  import gain_ramp_pkg::*;

  logic        a_clk = 1'b0;
  logic        a_resetn = 1'b0;
  logic [31:0] target_gain = '0;
  logic [31:0] step = '0;
  logic [15:0] prescale = '0;
  logic        enable = 1'b0;
  logic        mute = 1'b0;
  logic [31:0] gain_out;
  logic        ramping;
  logic        at_target;

  int testCount = 0;
  int failCount = 0;

  typedef struct {
    string       tag;
    logic [31:0] gain;
    logic        ramping;
    logic        at_target;
  } exp_t;

  exp_t sb[$];

  always #5 a_clk = ~a_clk;

  gain_slew_ramp dut (
    .a_clk       (a_clk),
    .a_resetn    (a_resetn),
    .target_gain (target_gain),
    .step        (step),
    .prescale    (prescale),
    .enable      (enable),
    .mute        (mute),
    .gain_out    (gain_out),
    .ramping     (ramping),
    .at_target   (at_target)
  );

  // Single comparison point: counts and reports.
  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] tgt, input logic [31:0] stp,
                               input logic [15:0] psc, input logic en, input logic mt);
    target_gain = tgt;
    step        = stp;
    prescale    = psc;
    enable      = en;
    mute        = mt;
  endtask

  task automatic expectCycle(input string tag, input logic [31:0] g, input logic r, input logic a);
    exp_t e;
    e.tag       = tag;
    e.gain      = g;
    e.ramping   = r;
    e.at_target = a;
    sb.push_back(e);
  endtask

  // Advance one clock, sample after the edge and compare against the scoreboard head.
  task automatic checkOutput();
    exp_t e;
    @(posedge a_clk);
    #1;
    if (sb.size() == 0) begin
      testCount++;
      failCount++;
      $display("[TB] FAIL sb_empty: observed empty scoreboard required an entry");
    end else begin
      e = sb.pop_front();
      checkValue({e.tag, ".gain"}, gain_out, e.gain);
      checkValue({e.tag, ".ramping"}, {31'd0, ramping}, {31'd0, e.ramping});
      checkValue({e.tag, ".at_target"}, {31'd0, at_target}, {31'd0, e.at_target});
    end
  endtask

  task automatic drain();
    while (sb.size() > 0) checkOutput();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    #12;
    checkValue("reset.gain", gain_out, 32'h0);
    checkValue("reset.ramping", {31'd0, ramping}, 32'd0);
    checkValue("reset.at_target", {31'd0, at_target}, 32'd0);
    @(negedge a_clk);
    a_resetn = 1'b1;
    @(posedge a_clk);
    #1;

    // 1: prescale 0, step 0x4000 toward unity
    applyStimulus(32'h0, 32'h4000, 16'd0, 1'b1, 1'b0);
    expectCycle("t1.idle", 32'h0, 1'b0, 1'b1);
    drain();
    applyStimulus(GAIN_UNITY_Q16, 32'h4000, 16'd0, 1'b1, 1'b0);
    expectCycle("t1.enter", 32'h0, 1'b1, 1'b0);
    expectCycle("t1.s1", 32'h4000, 1'b1, 1'b0);
    expectCycle("t1.s2", 32'h8000, 1'b1, 1'b0);
    expectCycle("t1.s3", 32'hC000, 1'b1, 1'b0);
    expectCycle("t1.done", 32'h1_0000, 1'b0, 1'b1);
    drain();

    // 2: same ramp with prescale 3, each value held four cycles
    applyStimulus(32'h0, 32'h0, 16'd0, 1'b1, 1'b0);
    expectCycle("t2.jump0", 32'h0, 1'b0, 1'b1);
    drain();
    applyStimulus(GAIN_UNITY_Q16, 32'h4000, 16'd3, 1'b1, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      expectCycle($sformatf("t2.c%0d", k), ((k - 1) / 4) * 32'h4000, 1'b1, 1'b0);
    end
    expectCycle("t2.done", 32'h1_0000, 1'b0, 1'b1);
    drain();

    // 3: clamp without overshoot, then immediate jump with step 0
    applyStimulus(32'h0, 32'h0, 16'd0, 1'b1, 1'b0);
    expectCycle("t3.jump0", 32'h0, 1'b0, 1'b1);
    drain();
    applyStimulus(GAIN_UNITY_Q16, 32'h6000, 16'd0, 1'b1, 1'b0);
    expectCycle("t3.enter", 32'h0, 1'b1, 1'b0);
    expectCycle("t3.s1", 32'h6000, 1'b1, 1'b0);
    expectCycle("t3.s2", 32'hC000, 1'b1, 1'b0);
    expectCycle("t3.clamp", 32'h1_0000, 1'b0, 1'b1);
    drain();
    applyStimulus(32'hFFFF_0000, 32'h0, 16'd0, 1'b1, 1'b0);
    expectCycle("t3.jump", 32'hFFFF_0000, 1'b0, 1'b1);
    drain();

    // 4a: mute mid-ramp reverses toward zero
    applyStimulus(32'h0, 32'h0, 16'd0, 1'b1, 1'b0);
    expectCycle("t4.jump0", 32'h0, 1'b0, 1'b1);
    drain();
    applyStimulus(GAIN_UNITY_Q16, 32'h4000, 16'd0, 1'b1, 1'b0);
    expectCycle("t4.enter", 32'h0, 1'b1, 1'b0);
    expectCycle("t4.s1", 32'h4000, 1'b1, 1'b0);
    expectCycle("t4.s2", 32'h8000, 1'b1, 1'b0);
    drain();
    applyStimulus(GAIN_UNITY_Q16, 32'h4000, 16'd0, 1'b1, 1'b1);
    expectCycle("t4.mute1", 32'h4000, 1'b1, 1'b0);
    expectCycle("t4.mute0", 32'h0, 1'b0, 1'b1);
    drain();

    // 4b: disable mid-ramp (prescale 1) freezes output and counter
    applyStimulus(GAIN_UNITY_Q16, 32'h4000, 16'd1, 1'b1, 1'b0);
    expectCycle("t4.f_enter", 32'h0, 1'b1, 1'b0);
    expectCycle("t4.f_c1", 32'h0, 1'b1, 1'b0);
    expectCycle("t4.f_s1", 32'h4000, 1'b1, 1'b0);
    expectCycle("t4.f_c2", 32'h4000, 1'b1, 1'b0);
    drain();
    applyStimulus(GAIN_UNITY_Q16, 32'h4000, 16'd1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      expectCycle($sformatf("t4.frozen%0d", k), 32'h4000, 1'b1, 1'b0);
    end
    drain();
    applyStimulus(GAIN_UNITY_Q16, 32'h4000, 16'd1, 1'b1, 1'b0);
    expectCycle("t4.r_s2", 32'h8000, 1'b1, 1'b0);
    expectCycle("t4.r_c3", 32'h8000, 1'b1, 1'b0);
    expectCycle("t4.r_s3", 32'hC000, 1'b1, 1'b0);
    expectCycle("t4.r_c4", 32'hC000, 1'b1, 1'b0);
    expectCycle("t4.r_done", 32'h1_0000, 1'b0, 1'b1);
    drain();

    // 5: full-scale descent without wrap, then |diff| == step boundary
    applyStimulus(32'h7FFF_FFFF, 32'h0, 16'd0, 1'b1, 1'b0);
    expectCycle("t5.jumpmax", 32'h7FFF_FFFF, 1'b0, 1'b1);
    drain();
    applyStimulus(32'h8000_0000, 32'h4000_0000, 16'd0, 1'b1, 1'b0);
    expectCycle("t5.enter", 32'h7FFF_FFFF, 1'b1, 1'b0);
    expectCycle("t5.s1", 32'h3FFF_FFFF, 1'b1, 1'b0);
    expectCycle("t5.s2", 32'hFFFF_FFFF, 1'b1, 1'b0);
    expectCycle("t5.s3", 32'hBFFF_FFFF, 1'b1, 1'b0);
    expectCycle("t5.clamp", 32'h8000_0000, 1'b0, 1'b1);
    drain();
    applyStimulus(32'h7FFF_FFFF, 32'hFFFF_FFFF, 16'd0, 1'b1, 1'b0);
    expectCycle("t5.up_enter", 32'h8000_0000, 1'b1, 1'b0);
    expectCycle("t5.up_clamp", 32'h7FFF_FFFF, 1'b0, 1'b1);
    drain();

    // 6: asynchronous reset between edges mid-ramp, then restart from zero
    applyStimulus(32'h0, 32'h0, 16'd0, 1'b1, 1'b0);
    expectCycle("t6.jump0", 32'h0, 1'b0, 1'b1);
    drain();
    applyStimulus(GAIN_UNITY_Q16, 32'h4000, 16'd0, 1'b1, 1'b0);
    expectCycle("t6.enter", 32'h0, 1'b1, 1'b0);
    expectCycle("t6.s1", 32'h4000, 1'b1, 1'b0);
    expectCycle("t6.s2", 32'h8000, 1'b1, 1'b0);
    drain();
    #3;
    a_resetn = 1'b0;
    #1;
    checkValue("t6.rst.gain", gain_out, 32'h0);
    checkValue("t6.rst.ramping", {31'd0, ramping}, 32'd0);
    checkValue("t6.rst.at_target", {31'd0, at_target}, 32'd0);
    #2;
    a_resetn = 1'b1;
    expectCycle("t6.re_enter", 32'h0, 1'b1, 1'b0);
    expectCycle("t6.re_s1", 32'h4000, 1'b1, 1'b0);
    expectCycle("t6.re_s2", 32'h8000, 1'b1, 1'b0);
    expectCycle("t6.re_s3", 32'hC000, 1'b1, 1'b0);
    expectCycle("t6.re_done", 32'h1_0000, 1'b0, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
